// File: rtl/rr_arbiter_2to1_32bit.sv
// ============================================================================
// Module   : rr_arbiter_2to1_32bit
// Brief    : Two-source round-robin arbiter feeding a single-entry valid/ready
//            output register through a 32-bit 2:1 mux. Optional ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2to1_32bit #(
    parameter int   DATA_W    = 32,
    parameter logic PRIO_INIT = 1'b0,
    parameter int   LOCK_MAX  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
`ifdef ARB_LOCK_EN
    input  logic [1:0]        req_lock,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready
);

    if (DATA_W != 32 || LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_bad_cfg
        $error("rr_arbiter_2to1_32bit: unsupported DATA_W or LOCK_MAX");
    end

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic              prio_q, prio_d;

    logic              both_vld;
    logic              any_vld;
    logic              grant;
    logic              can_load;
    logic              xfer;
    logic [DATA_W-1:0] mux_out;

    always_comb begin
        both_vld = req0_valid & req1_valid;
        any_vld  = req0_valid | req1_valid;
        grant    = both_vld ? prio_q : req1_valid;
        // Ready is suppressed while reset is asserted so nothing is accepted then lost.
        can_load = ~reset & ((state_q == ST_EMPTY) | (out_ready & (state_q == ST_FULL)));
        xfer     = can_load & any_vld;
        mux_out  = grant ? req1_data : req0_data;
    end

    assign req0_ready = xfer & ~grant;
    assign req1_ready = xfer &  grant;
    assign out_valid  = (state_q == ST_FULL);
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;

`ifdef ARB_LOCK_EN
    localparam logic [3:0] c_lock_max = 4'(LOCK_MAX);

    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       lock_src_q, lock_src_d;
    logic [3:0] lock_cnt_inc;
`endif

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        prio_d     = prio_q;
`ifdef ARB_LOCK_EN
        lock_cnt_d   = lock_cnt_q;
        lock_src_d   = lock_src_q;
        lock_cnt_inc = (lock_src_q == grant) ? lock_cnt_q + 4'd1 : 4'd1;
`endif
        if (xfer) begin
            state_d    = ST_FULL;
            out_data_d = mux_out;
            out_src_d  = grant;
            prio_d     = ~grant;
`ifdef ARB_LOCK_EN
            // Lock only matters under contention; an idle competitor leaves the count alone.
            if (both_vld) begin
                if (req_lock[grant]) begin
                    lock_src_d = grant;
                    if (lock_cnt_inc == c_lock_max) begin
                        prio_d     = ~grant;
                        lock_cnt_d = 4'd0;
                    end else begin
                        prio_d     = grant;
                        lock_cnt_d = lock_cnt_inc;
                    end
                end else begin
                    lock_cnt_d = 4'd0;
                end
            end else if (!req_lock[grant]) begin
                lock_cnt_d = 4'd0;
            end
`endif
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_src_q  <= 1'b0;
            prio_q     <= PRIO_INIT;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            prio_q     <= prio_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q <= 4'd0;
            lock_src_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_src_q <= lock_src_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_2to1_32bit.sv
// ============================================================================
// Module   : tb_rr_arbiter_2to1_32bit
// Brief    : Self-checking bench for rr_arbiter_2to1_32bit (vectors + random model).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rr_arbiter_2to1_32bit;

    localparam logic [31:0] c_a = 32'h1111_1111;
    localparam logic [31:0] c_b = 32'h2222_2222;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data, out_data;
    logic        out_valid, out_src, out_ready;
`ifdef ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arbiter_2to1_32bit dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
`ifdef ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    typedef struct packed {
        logic        rst;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        ordy;
        logic        r0;
        logic        r1;
        logic        ov;
        logic [31:0] od;
        logic        osrc;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v0, input logic [31:0] d0, input logic v1,
                          input logic [31:0] d1, input logic ordy);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        out_ready  = ordy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Random-stress reference: tie goes to 'turn', any grant hands the turn to the other side.
    logic        m_full, m_src, turn, win, can, any_v;
    logic [31:0] m_word;
    int          wait0, wait1;
    logic        acc0, acc1;

    initial begin
        // Each row: inputs for one cycle, then expected readies and pre-edge output register.
        vecs[0]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, c_a,          1'b1, c_b,   1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b1, c_a,          1'b1, c_b,   1'b1, 1'b1, 1'b0, 1'b1, c_b,          1'b1};
        vecs[4]  = '{1'b0, 1'b1, c_a,          1'b1, c_b,   1'b0, 1'b0, 1'b0, 1'b1, c_a,          1'b0};
        vecs[5]  = '{1'b0, 1'b1, c_a,          1'b1, c_b,   1'b0, 1'b0, 1'b0, 1'b1, c_a,          1'b0};
        vecs[6]  = '{1'b0, 1'b1, c_a,          1'b1, c_b,   1'b1, 1'b0, 1'b1, 1'b1, c_a,          1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, c_b,          1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b1};
        vecs[10] = '{1'b1, 1'b1, c_a,          1'b1, c_b,   1'b1, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b1};
        vecs[11] = '{1'b0, 1'b1, c_a,          1'b1, c_b,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, c_a,          1'b0};

        do_reset();
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_src", out_src, 0);
        chk("reset ready0", req0_ready, 0);
        chk("reset ready1", req1_ready, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            reset = vecs[i].rst;
            set_in(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d ready0", i), req0_ready, vecs[i].r0);
            chk($sformatf("vec%0d ready1", i), req1_ready, vecs[i].r1);
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
                chk($sformatf("vec%0d out_src", i), out_src, vecs[i].osrc);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;

        // Continuous contention with a free-running consumer alternates sources every cycle.
        do_reset();
        set_in(1'b1, c_a, 1'b1, c_b, 1'b1);
        @(negedge clk);
        chk("alt first ready0", req0_ready, 1);
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("alt%0d out_valid", k), out_valid, 1);
            chk($sformatf("alt%0d out_src", k), out_src, 32'(k % 2));
            chk($sformatf("alt%0d out_data", k), out_data, (k % 2) ? c_b : c_a);
            @(posedge clk); #1;
        end

        // Stall while full, then release: drain and reload in the same cycle.
        do_reset();
        set_in(1'b1, c_a, 1'b1, c_b, 1'b0);
        @(negedge clk);
        chk("stall load ready0", req0_ready, 1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d ready0", k), req0_ready, 0);
            chk($sformatf("stall%0d ready1", k), req1_ready, 0);
            chk($sformatf("stall%0d out_valid", k), out_valid, 1);
            chk($sformatf("stall%0d out_data", k), out_data, c_a);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release ready1", req1_ready, 1);
        @(posedge clk); #1;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("release out_valid", out_valid, 1);
        chk("release out_data", out_data, c_b);
        chk("release out_src", out_src, 1);
        @(posedge clk); #1;

`ifdef ARB_LOCK_EN
        begin
            logic [5:0] exp_src;
            exp_src = 6'b010000;
            do_reset();
            req_lock = 2'b01;
            set_in(1'b1, c_a, 1'b1, c_b, 1'b1);
            @(posedge clk); #1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk($sformatf("lock%0d out_src", k), out_src, 32'(exp_src[k]));
                @(posedge clk); #1;
            end
            req_lock = 2'b00;
        end
`endif

        // Randomised stress against the reference model.
        do_reset();
        m_full = 1'b0; m_src = 1'b0; m_word = 32'h0; turn = 1'b0;
        wait0 = 0; wait1 = 0; acc0 = 1'b0; acc1 = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 99) < 60) begin
                req0_valid = 1'b1;
                req0_data  = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 99) < 60) begin
                req1_valid = 1'b1;
                req1_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 99) < 70);
            @(negedge clk);
            can   = !m_full || out_ready;
            any_v = req0_valid || req1_valid;
            win   = (req0_valid && req1_valid) ? turn : req1_valid;
            chk("rnd ready0", req0_ready, 32'(can && any_v && !win));
            chk("rnd ready1", req1_ready, 32'(can && any_v && win));
            chk("rnd out_valid", out_valid, 32'(m_full));
            if (m_full) begin
                chk("rnd out_data", out_data, m_word);
                chk("rnd out_src", out_src, 32'(m_src));
            end
            acc0 = 1'b0;
            acc1 = 1'b0;
            if (can && any_v) begin
                if (win) begin
                    acc1 = 1'b1; wait1 = 0;
                    if (req0_valid) wait0++;
                    chk("rnd wait0 bound", 32'(wait0 <= 1), 1);
                end else begin
                    acc0 = 1'b1; wait0 = 0;
                    if (req1_valid) wait1++;
                    chk("rnd wait1 bound", 32'(wait1 <= 1), 1);
                end
                m_full = 1'b1;
                m_word = win ? req1_data : req0_data;
                m_src  = win;
                turn   = ~win;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
